sobel_window_ctrl: RTL and testbench



---
 rtl/sobel_pkg.sv | 21 ++
 rtl/SobelFilter.sv | 39 +++
 rtl/sobel_line_buffer.sv | 56 +++++
 rtl/sobel_window_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window controller slice.
package sobel_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int PIX_W     = 12;
    localparam int XW_DEF    = $clog2(IMG_W_DEF);
    localparam int YW_DEF    = $clog2(IMG_H_DEF);

    // Gradient magnitude above this value marks an edge.
    localparam logic [15:0] EDGE_THRESH = 16'd2500;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/SobelFilter.sv
// Combinational 3x3 Sobel edge kernel: signed 16-bit gx/gy, edge when |gx|+|gy| > threshold.
// The centre tap does not contribute to either gradient, so it has no port.
module SobelFilter
    import sobel_pkg::*;
(
    input  pixel_t data00,
    input  pixel_t data01,
    input  pixel_t data02,
    input  pixel_t data10,
    input  pixel_t data12,
    input  pixel_t data20,
    input  pixel_t data21,
    input  pixel_t data22,
    output logic   edge_out
);

    function automatic logic signed [15:0] ext(input pixel_t p);
        return $signed({4'b0000, p});
    endfunction

    logic signed [15:0] gx_s;
    logic signed [15:0] gy_s;
    logic signed [15:0] ax_s;
    logic signed [15:0] ay_s;
    logic        [15:0] mag_s;

    // Gradients, absolute values and threshold decision.
    always_comb begin
        gx_s = (ext(data02) + (ext(data12) <<< 1) + ext(data22))
             - (ext(data00) + (ext(data10) <<< 1) + ext(data20));
        gy_s = (ext(data20) + (ext(data21) <<< 1) + ext(data22))
             - (ext(data00) + (ext(data01) <<< 1) + ext(data02));
        ax_s = (gx_s < 16'sd0) ? -gx_s : gx_s;
        ay_s = (gy_s < 16'sd0) ? -gy_s : gy_s;
        mag_s = $unsigned(ax_s) + $unsigned(ay_s);
        edge_out = (mag_s > EDGE_THRESH);
    end

endmodule

// File: rtl/sobel_line_buffer.sv
// Two line buffers (rows y-1 and y-2) with synchronous read returning old data.
// Row y-1 is written with the incoming pixel on the accepting edge; the displaced
// row y-1 value reaches row y-2 one edge later, once it has been read out.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter  int DEPTH = IMG_W_DEF,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  pixel_t        wdata_i,
    output pixel_t        row1_o,
    output pixel_t        row2_o
);

    pixel_t        row1_mem [DEPTH];
    pixel_t        row2_mem [DEPTH];
    pixel_t        row1_q;
    pixel_t        row2_q;
    logic          pend_q;
    logic [AW-1:0] pend_addr_q;

    // Read both rows at the accepted column and overwrite row y-1 with the new pixel.
    always_ff @(posedge clk) begin
        if (en_i) begin
            row1_q           <= row1_mem[addr_i];
            row2_q           <= row2_mem[addr_i];
            row1_mem[addr_i] <= wdata_i;
        end
    end

    // Remember which column still owes its old row y-1 value to row y-2.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pend_q      <= en_i;
            pend_addr_q <= addr_i;
        end
    end

    // Push the displaced row y-1 value down into row y-2.
    always_ff @(posedge clk) begin
        if (pend_q) begin
            row2_mem[pend_addr_q] <= row1_q;
        end
    end

    assign row1_o = row1_q;
    assign row2_o = row2_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster pixel stream -> 3x3 windows -> registered Sobel edge bit per centre.
// Pipeline: S1 RAM read + coordinates, S2 window shift, S3 kernel result register.
// Optional build macro SOBEL_DBG_CENTER_EN adds o_center (registered centre gray value).
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter  int IMG_W = IMG_W_DEF,
    parameter  int IMG_H = IMG_H_DEF,
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_sof,
    input  logic          i_de,
    input  pixel_t        i_gray,
    output logic          o_valid,
    output logic          o_edge,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_frame_done
`ifdef SOBEL_DBG_CENTER_EN
    ,
    output pixel_t        o_center
`endif
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t        state_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic          acc_s;
    logic [XW-1:0] px_s;
    logic [YW-1:0] py_s;
    logic          last_px_s;

    pixel_t        row1_s;
    pixel_t        row2_s;

    logic          sh1_q, v1_q, done1_q;
    logic [XW-1:0] cx1_q;
    logic [YW-1:0] cy1_q;
    pixel_t        gray1_q;

    logic          v2_q, done2_q;
    logic [XW-1:0] cx2_q;
    logic [YW-1:0] cy2_q;

    pixel_t        top_q [3];
    pixel_t        mid_q [3];
    pixel_t        bot_q [3];

    logic          kern_edge_s;
    logic          edge_d;

    // Acceptance and the coordinate of the pixel on the bus (i_sof forces (0,0)).
    always_comb begin
        acc_s = i_de && (i_sof || (state_q == ACTIVE));
        if (i_sof) begin
            px_s = '0;
            py_s = '0;
        end else begin
            px_s = x_q;
            py_s = y_q;
        end
        last_px_s = (px_s == X_LAST) && (py_s == Y_LAST);
    end

    // Next raster position: advance on acceptance, restart on i_sof, otherwise hold.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (acc_s) begin
            if (px_s == X_LAST) begin
                x_d = '0;
                y_d = (py_s == Y_LAST) ? '0 : py_s + YW'(1);
            end else begin
                x_d = px_s + XW'(1);
                y_d = py_s;
            end
        end else if (i_sof) begin
            x_d = '0;
            y_d = '0;
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Raster position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Frame FSM; a mid-frame i_sof simply restarts in ACTIVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_sof) state_q <= ACTIVE;
                    else       state_q <= IDLE;
                end
                ACTIVE: begin
                    if (i_sof)                       state_q <= ACTIVE;
                    else if (acc_s && last_px_s)     state_q <= DONE;
                    else                             state_q <= ACTIVE;
                end
                DONE: begin
                    if (i_sof) state_q <= ACTIVE;
                    else       state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sobel_line_buffer #(
        .DEPTH (IMG_W)
    ) u_lbuf (
        .clk     (clk),
        .reset   (reset),
        .en_i    (acc_s),
        .addr_i  (px_s),
        .wdata_i (i_gray),
        .row1_o  (row1_s),
        .row2_o  (row2_s)
    );

    // S1: tag the accepted pixel with the centre it completes, if any.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh1_q   <= 1'b0;
            v1_q    <= 1'b0;
            done1_q <= 1'b0;
            cx1_q   <= '0;
            cy1_q   <= '0;
            gray1_q <= '0;
        end else begin
            sh1_q   <= acc_s;
            v1_q    <= acc_s && (px_s != '0) && (py_s != '0);
            done1_q <= acc_s && last_px_s;
            cx1_q   <= px_s - XW'(1);
            cy1_q   <= py_s - YW'(1);
            gray1_q <= i_gray;
        end
    end

    // S2: shift the window one column left; new right column is {row y-2, row y-1, current}.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
            v2_q    <= 1'b0;
            done2_q <= 1'b0;
            cx2_q   <= '0;
            cy2_q   <= '0;
        end else begin
            if (sh1_q) begin
                top_q[0] <= top_q[1];
                top_q[1] <= top_q[2];
                top_q[2] <= row2_s;
                mid_q[0] <= mid_q[1];
                mid_q[1] <= mid_q[2];
                mid_q[2] <= row1_s;
                bot_q[0] <= bot_q[1];
                bot_q[1] <= bot_q[2];
                bot_q[2] <= gray1_q;
            end
            v2_q    <= v1_q;
            done2_q <= done1_q;
            cx2_q   <= cx1_q;
            cy2_q   <= cy1_q;
        end
    end

    SobelFilter u_kernel (
        .data00   (top_q[0]),
        .data01   (top_q[1]),
        .data02   (top_q[2]),
        .data10   (mid_q[0]),
        .data12   (mid_q[2]),
        .data20   (bot_q[0]),
        .data21   (bot_q[1]),
        .data22   (bot_q[2]),
        .edge_out (kern_edge_s)
    );

    // Border centres (column 0 or row 0) see an incomplete window, so their edge is forced low.
    always_comb begin
        if (v2_q && (cx2_q != '0) && (cy2_q != '0)) begin
            edge_d = kern_edge_s;
        end else begin
            edge_d = 1'b0;
        end
    end

    // S3: register the kernel result and its centre tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid      <= 1'b0;
            o_edge       <= 1'b0;
            o_x          <= '0;
            o_y          <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= v2_q;
            o_edge       <= edge_d;
            o_x          <= cx2_q;
            o_y          <= cy2_q;
            o_frame_done <= done2_q;
        end
    end

`ifdef SOBEL_DBG_CENTER_EN
    // Debug: centre gray value aligned with o_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_center <= '0;
        end else begin
            o_center <= mid_q[1];
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl with an 8x6 image.
module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          i_sof  = 1'b0;
    logic          i_de   = 1'b0;
    pixel_t        i_gray = '0;
    logic          o_valid;
    logic          o_edge;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_frame_done;
`ifdef SOBEL_DBG_CENTER_EN
    pixel_t        o_center;
`endif

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        edg;
        logic        done;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   img [H][W];

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_sof        (i_sof),
        .i_de         (i_de),
        .i_gray       (i_gray),
        .o_valid      (o_valid),
        .o_edge       (o_edge),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_done (o_frame_done)
`ifdef SOBEL_DBG_CENTER_EN
        ,
        .o_center     (o_center)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every result strobe away from the active edge.
    always @(negedge clk) begin
        if (o_valid || o_frame_done)
            obs_q.push_back('{cyc: 32'(cyc), x: 8'(o_x), y: 8'(o_y), edg: o_edge, done: o_frame_done});
    end

    function automatic int pix_val(input int mode, input int x);
        case (mode)
            0:       return 100;
            1:       return (x >= 4) ? 4095 : 0;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    // Reference Sobel on the stored image: border centres are 0.
    function automatic logic model_edge(input int cx, input int cy);
        int gx, gy;
        if (cx == 0 || cy == 0) return 1'b0;
        gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
        gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) > 2500;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_sof  = 1'b0;
            i_de   = 1'b0;
            i_gray = pixel_t'($urandom_range(0, 4095));
            @(posedge clk); #1;
        end
    endtask

    // Drive one frame (i_sof with the first pixel); gap 0=none, 1=two idle cycles, 2=random.
    task automatic drive_frame(input int mode, input int gap, input int stop_at);
        for (int i = 0; i < W*H; i++) begin
            int x, y, g;
            if (i == stop_at) break;
            x = i % W;
            y = i / W;
            if (i != 0) begin
                g = (gap == 1) ? 2 : ((gap == 2) ? int'($urandom_range(0, 3)) : 0);
                idle(g);
            end
            img[y][x] = pix_val(mode, x);
            i_sof  = (i == 0);
            i_de   = 1'b1;
            i_gray = pixel_t'(img[y][x]);
            @(posedge clk); #1;
            if (x >= 1 && y >= 1)
                exp_q.push_back('{cyc: 32'(cyc + 2), x: 8'(x - 1), y: 8'(y - 1),
                                  edg: model_edge(x - 1, y - 1),
                                  done: (x == W-1 && y == H-1)});
            i_sof = 1'b0;
            i_de  = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            reset = 1'b1; i_de = 1'b1; i_sof = 1'b0;
            i_gray = pixel_t'($urandom_range(0, 4095));
            @(posedge clk); #1;
            checks++;
            if ({o_valid, o_edge, o_x, o_y, o_frame_done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got v=%0b e=%0b x=%0d y=%0d fd=%0b want all 0",
                         o_valid, o_edge, o_x, o_y, o_frame_done);
            end
        end
        reset = 1'b0;
        obs_q.delete();
        for (int k = 0; k < 12; k++) begin
            i_de = 1'b1; i_gray = pixel_t'($urandom_range(0, 4095));
            @(posedge clk); #1;
        end
        idle(5);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL no_sof_ignored: got %0d results want 0", obs_q.size());
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL no_sof_state: got %0d want %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_flat();
        int nd;
        exp_q.delete(); obs_q.delete();
        drive_frame(0, 0, -1);
        idle(6);
        checks++;
        if (obs_q.size() != 35) begin
            errors++;
            $display("FAIL flat_count: got %0d want 35", obs_q.size());
        end
        if (obs_q.size() == 35) begin
            checks++;
            if (obs_q[0].x != 0 || obs_q[0].y != 0 || obs_q[34].x != 6 || obs_q[34].y != 4 || !obs_q[34].done) begin
                errors++;
                $display("FAIL flat_ends: got first (%0d,%0d) last (%0d,%0d) done=%0b want (0,0) (6,4) 1",
                         obs_q[0].x, obs_q[0].y, obs_q[34].x, obs_q[34].y, obs_q[34].done);
            end
        end
        nd = 0;
        foreach (obs_q[i]) begin
            nd += int'(obs_q[i].done);
            checks++;
            if (obs_q[i].edg !== 1'b0) begin
                errors++;
                $display("FAIL flat_edge[%0d]: got 1 want 0", i);
            end
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL flat_done_count: got %0d want 1", nd);
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL flat_rec[%0d]: got cyc=%0d (%0d,%0d) e=%0b d=%0b want cyc=%0d (%0d,%0d) e=%0b d=%0b", i,
                             obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].edg, obs_q[i].done,
                             exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].edg, exp_q[i].done);
                end
            end
        end
    endtask

    // gap=0 continuous, gap=1 i_de pattern 1,0,0,1,...
    task automatic test_step(input int gap);
        int ne;
        exp_q.delete(); obs_q.delete();
        drive_frame(1, gap, -1);
        idle(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL step%0d_count: got %0d want %0d", gap, obs_q.size(), exp_q.size());
        end
        ne = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].edg) begin
                ne++;
                checks++;
                if (!((obs_q[i].x == 3 || obs_q[i].x == 4) && obs_q[i].y >= 1)) begin
                    errors++;
                    $display("FAIL step%0d_edge_pos: got edge at (%0d,%0d) want cx in {3,4}, cy>=1",
                             gap, obs_q[i].x, obs_q[i].y);
                end
            end
        end
        checks++;
        if (ne != 8) begin
            errors++;
            $display("FAIL step%0d_edge_count: got %0d want 8", gap, ne);
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL step%0d_rec[%0d]: got cyc=%0d (%0d,%0d) e=%0b d=%0b want cyc=%0d (%0d,%0d) e=%0b d=%0b", gap, i,
                             obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].edg, obs_q[i].done,
                             exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].edg, exp_q[i].done);
                end
            end
        end
    endtask

    task automatic test_abort();
        int nd;
        exp_q.delete(); obs_q.delete();
        drive_frame(2, 0, 3*W + 2);
        drive_frame(0, 0, -1);
        idle(6);
        nd = 0;
        foreach (obs_q[i]) nd += int'(obs_q[i].done);
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL abort_done_count: got %0d want 1", nd);
        end
        checks++;
        if (obs_q.size() < 35 || obs_q[obs_q.size()-35].x != 0 || obs_q[obs_q.size()-35].y != 0) begin
            errors++;
            $display("FAIL abort_frame2_start: got %0d results want frame 2 starting at (0,0)", obs_q.size());
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL abort_rec[%0d]: got cyc=%0d (%0d,%0d) e=%0b d=%0b want cyc=%0d (%0d,%0d) e=%0b d=%0b", i,
                             obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].edg, obs_q[i].done,
                             exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].edg, exp_q[i].done);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_frame(2, 0, 2*W + 3);
        reset = 1'b1; i_de = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_valid !== 1'b0 || o_frame_done !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL midreset_clear: got v=%0b fd=%0b state=%0d want 0 0 %0d",
                     o_valid, o_frame_done, dut.state_q, IDLE);
        end
        reset = 1'b0; i_de = 1'b0;
        exp_q.delete(); obs_q.delete();
        idle(5);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d results want 0", obs_q.size());
        end
        drive_frame(0, 0, -1);
        idle(6);
        checks++;
        if (obs_q.size() != 35) begin
            errors++;
            $display("FAIL midreset_count: got %0d want 35", obs_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL midreset_rec[%0d]: got cyc=%0d (%0d,%0d) e=%0b d=%0b want cyc=%0d (%0d,%0d) e=%0b d=%0b", i,
                             obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].edg, obs_q[i].done,
                             exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].edg, exp_q[i].done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        exp_q.delete(); obs_q.delete();
        drive_frame(0, 0, -1);
        drive_frame(1, 0, -1);
        drive_frame(2, 2, -1);
        idle(6);
        nd = 0;
        foreach (obs_q[i]) nd += int'(obs_q[i].done);
        checks++;
        if (nd != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d want 3", nd);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_rec[%0d]: got cyc=%0d (%0d,%0d) e=%0b d=%0b want cyc=%0d (%0d,%0d) e=%0b d=%0b", i,
                             obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].edg, obs_q[i].done,
                             exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].edg, exp_q[i].done);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_step(0);
        test_step(1);
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
